vga_pixel_packer: RTL and testbench

Downstream neighbour of the VGA input indexer. It consumes the per-pixel row/column index and valid strobe, along with the AD9880 RGB data for the same cycle, and packs horizontally adjacent pixel pairs into 64-bit words. Each word carries a pixel-pair write address and a per-pixel mask. An 8-entry output FIFO with a valid/ready handshake holds the words for the frame-buffer writer. Overflow is detected, the word is dropped and the event is flagged, so the capture path never stalls.

---
 rtl/vga_pixel_packer_pkg.sv | 27 ++
 rtl/vga_pixel_packer_fifo.sv | 71 +++++++
 rtl/vga_pixel_packer.sv | 172 +++++++++++++++++
 tb/tb_vga_pixel_packer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pixel_packer_pkg.sv
// Shared encodings for the VGA pixel-pair packer: masks, packer states and pixel word format.
package vga_pixel_packer_pkg;

   localparam int unsigned PIX_W = 32;

   localparam logic [1:0] MASK_EVEN = 2'b01;
   localparam logic [1:0] MASK_ODD  = 2'b10;
   localparam logic [1:0] MASK_PAIR = 2'b11;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HALF  = 1'b1
   } pack_state_e;

   typedef struct packed {
      logic [PIX_W-1:0] odd;
      logic [PIX_W-1:0] even;
   } pixel_pair_t;

   // One pixel in a 32-bit lane: {8'h00, R, G, B}
   function automatic logic [PIX_W-1:0] pixel_word(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
      return {8'h00, r, g, b};
   endfunction

endpackage

// File: rtl/vga_pixel_packer_fifo.sv
// First-word-fall-through FIFO taking up to two pushes and one pop per cycle.
// Pushes that do not fit after the same-cycle pop are dropped, newest first.
module pixel_word_fifo #(
   parameter int unsigned Width = 87,
   parameter int unsigned Depth = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push0_valid,
   input  logic [Width-1:0]        push0_data,
   input  logic                    push1_valid,
   input  logic [Width-1:0]        push1_data,
   input  logic                    pop_ready,
   output logic                    head_valid,
   output logic [Width-1:0]        head_data,
   output logic [$clog2(Depth):0]  level,
   output logic                    drop_c
);

   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned LevelW = PtrW + 1;

   logic [Width-1:0]  mem [Depth];
   logic [PtrW-1:0]   rd_ptr;
   logic [PtrW-1:0]   wr_ptr;
   logic              pop;
   logic              acc0;
   logic              acc1;
   logic [1:0]        n_acc;
   logic [LevelW-1:0] space;
   logic [LevelW-1:0] level_d;

   // Space is judged after this cycle's pop; push0 is always the older word
   always_comb begin
      pop     = head_valid & pop_ready;
      space   = LevelW'(Depth) - (level - LevelW'(pop));
      acc0    = push0_valid && (space != '0);
      acc1    = push1_valid && (space > (acc0 ? LevelW'(1) : LevelW'(0)));
      drop_c  = (push0_valid & ~acc0) | (push1_valid & ~acc1);
      n_acc   = 2'(acc0) + 2'(acc1);
      level_d = level - LevelW'(pop) + LevelW'(n_acc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         head_valid <= 1'b0;
         for (int unsigned k = 0; k < Depth; k++) begin
            mem[PtrW'(k)] <= '0;
         end
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PtrW'(1);
         end
         if (acc0) begin
            mem[wr_ptr] <= push0_data;
         end
         if (acc1) begin
            mem[acc0 ? (wr_ptr + PtrW'(1)) : wr_ptr] <= push1_data;
         end
         wr_ptr     <= wr_ptr + PtrW'(n_acc);
         level      <= level_d;
         head_valid <= (level_d != '0);
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/vga_pixel_packer.sv
// Packs horizontally adjacent VGA pixels into 64-bit pair words with address and mask,
// buffered in a small FIFO; overflowing words are dropped and flagged.
module vga_pixel_packer
   import vga_pixel_packer_pkg::*;
#(
   parameter int unsigned Depth = 8,
   parameter int unsigned AddrW = 21
) (
   input  logic                    VGA_IN_DATA_CLK,
   input  logic                    Reset_n,
   input  logic [10:0]             i,
   input  logic [10:0]             j,
   input  logic                    valid,
   input  logic [7:0]              VGA_IN_RED,
   input  logic [7:0]              VGA_IN_GREEN,
   input  logic [7:0]              VGA_IN_BLUE,
   output logic                    OutValid,
   input  logic                    OutReady,
   output logic [AddrW-1:0]        OutAddr,
   output logic [63:0]             OutData,
   output logic [1:0]              OutMask,
   output logic                    FrameStart,
   output logic                    Overflow,
   output logic [$clog2(Depth):0]  Level
);

   localparam int unsigned DataW = 2 * PIX_W;
   localparam int unsigned WordW = AddrW + 2 + DataW;

   // Sampled input pixel
   logic             s_valid;
   logic [10:0]      s_i;
   logic [10:0]      s_j;
   logic [PIX_W-1:0] s_pix;

   // Packer state and held even pixel
   pack_state_e      state,    state_d;
   logic [10:0]      held_i,   held_i_d;
   logic [10:0]      held_j,   held_j_d;
   logic [PIX_W-1:0] held_pix, held_pix_d;

   // Registered push slots; p1 is only ever used alongside p0
   logic             p0_valid, p0_valid_d;
   logic [WordW-1:0] p0_word,  p0_word_d;
   logic             p1_valid, p1_valid_d;
   logic [WordW-1:0] p1_word,  p1_word_d;

   logic             take_new;
   logic             emit_held;
   logic             fifo_drop_c;
   logic [WordW-1:0] head_word;

   function automatic logic [WordW-1:0] make_word(input logic [10:0]  wi,
                                                  input logic [9:0]   wj_hi,
                                                  input logic [1:0]   mask,
                                                  input pixel_pair_t  pair);
      return {AddrW'({wi, wj_hi}), mask, pair};
   endfunction

   always_ff @(posedge VGA_IN_DATA_CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         s_valid    <= 1'b0;
         s_i        <= '0;
         s_j        <= '0;
         s_pix      <= '0;
         FrameStart <= 1'b0;
         Overflow   <= 1'b0;
      end else begin
         s_valid    <= valid;
         s_i        <= i;
         s_j        <= j;
         s_pix      <= pixel_word(VGA_IN_RED, VGA_IN_GREEN, VGA_IN_BLUE);
         FrameStart <= valid && (i == 11'd0) && (j == 11'd0);
         // A drop in the same cycle wins over the frame-start clear
         Overflow   <= fifo_drop_c | (Overflow & ~FrameStart);
      end
   end

   always_ff @(posedge VGA_IN_DATA_CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_EMPTY;
         held_i   <= '0;
         held_j   <= '0;
         held_pix <= '0;
         p0_valid <= 1'b0;
         p0_word  <= '0;
         p1_valid <= 1'b0;
         p1_word  <= '0;
      end else begin
         state    <= state_d;
         held_i   <= held_i_d;
         held_j   <= held_j_d;
         held_pix <= held_pix_d;
         p0_valid <= p0_valid_d;
         p0_word  <= p0_word_d;
         p1_valid <= p1_valid_d;
         p1_word  <= p1_word_d;
      end
   end

   always_comb begin
      state_d    = state;
      held_i_d   = held_i;
      held_j_d   = held_j;
      held_pix_d = held_pix;
      p0_valid_d = 1'b0;
      p0_word_d  = '0;
      p1_valid_d = 1'b0;
      p1_word_d  = '0;
      take_new   = 1'b0;
      emit_held  = 1'b0;

      case (state)
         ST_EMPTY: take_new = s_valid;
         ST_HALF: begin
            state_d = ST_EMPTY;
            if (s_valid && (s_i == held_i) && (s_j == (held_j + 11'd1))) begin
               p0_valid_d = 1'b1;
               p0_word_d  = make_word(held_i, held_j[10:1], MASK_PAIR,
                                      pixel_pair_t'{odd: s_pix, even: held_pix});
            end else begin
               // Break in the pair (gap, jump or new row): flush the held pixel first
               emit_held  = 1'b1;
               take_new   = s_valid;
               p0_valid_d = 1'b1;
               p0_word_d  = make_word(held_i, held_j[10:1], MASK_EVEN,
                                      pixel_pair_t'{odd: '0, even: held_pix});
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      if (take_new) begin
         if (!s_j[0]) begin
            state_d    = ST_HALF;
            held_i_d   = s_i;
            held_j_d   = s_j;
            held_pix_d = s_pix;
         end else if (emit_held) begin
            p1_valid_d = 1'b1;
            p1_word_d  = make_word(s_i, s_j[10:1], MASK_ODD,
                                   pixel_pair_t'{odd: s_pix, even: '0});
         end else begin
            p0_valid_d = 1'b1;
            p0_word_d  = make_word(s_i, s_j[10:1], MASK_ODD,
                                   pixel_pair_t'{odd: s_pix, even: '0});
         end
      end
   end

   pixel_word_fifo #(
      .Width (WordW),
      .Depth (Depth)
   ) u_fifo (
      .clk         (VGA_IN_DATA_CLK),
      .rst_n       (Reset_n),
      .push0_valid (p0_valid),
      .push0_data  (p0_word),
      .push1_valid (p1_valid),
      .push1_data  (p1_word),
      .pop_ready   (OutReady),
      .head_valid  (OutValid),
      .head_data   (head_word),
      .level       (Level),
      .drop_c      (fifo_drop_c)
   );

   assign OutAddr = head_word[WordW-1 -: AddrW];
   assign OutMask = head_word[DataW +: 2];
   assign OutData = head_word[DataW-1:0];

endmodule

// File: tb/tb_vga_pixel_packer.sv
// Directed bench for vga_pixel_packer: row table plus hand sequences for split pairs,
// overflow, latency and mid-line reset.
module tb_vga_pixel_packer;

   logic        clk;
   logic        Reset_n;
   logic [10:0] i;
   logic [10:0] j;
   logic        valid;
   logic [7:0]  VGA_IN_RED;
   logic [7:0]  VGA_IN_GREEN;
   logic [7:0]  VGA_IN_BLUE;
   logic        OutValid;
   logic        OutReady;
   logic [20:0] OutAddr;
   logic [63:0] OutData;
   logic [1:0]  OutMask;
   logic        FrameStart;
   logic        Overflow;
   logic [3:0]  Level;

   vga_pixel_packer dut (
      .VGA_IN_DATA_CLK (clk),
      .Reset_n         (Reset_n),
      .i               (i),
      .j               (j),
      .valid           (valid),
      .VGA_IN_RED      (VGA_IN_RED),
      .VGA_IN_GREEN    (VGA_IN_GREEN),
      .VGA_IN_BLUE     (VGA_IN_BLUE),
      .OutValid        (OutValid),
      .OutReady        (OutReady),
      .OutAddr         (OutAddr),
      .OutData         (OutData),
      .OutMask         (OutMask),
      .FrameStart      (FrameStart),
      .Overflow        (Overflow),
      .Level           (Level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [20:0] addr;
      logic [1:0]  mask;
      logic [63:0] data;
   } word_t;

   typedef struct {
      logic [10:0] row;
      logic [10:0] j0;
      int          n;
      int          words;
      logic [20:0] a_first;
      logic [1:0]  m_first;
      logic [20:0] a_last;
      logic [1:0]  m_last;
   } row_vec_t;

   word_t    got[$];
   row_vec_t vecs[6];
   int       tests  = 0;
   int       failed = 0;

   // Words are captured on the falling edge before the rising edge that transfers them
   always @(negedge clk) begin
      if (Reset_n && OutValid && OutReady) got.push_back('{OutAddr, OutMask, OutData});
   end

   function automatic logic [31:0] pix(input logic [10:0] pi, input logic [10:0] pj);
      logic [7:0] b;
      b = {5'b0, pj[10:8]} ^ 8'hA5;
      return {8'h00, pj[7:0], pi[7:0], b};
   endfunction

   function automatic logic [63:0] exp_data(input logic [20:0] a, input logic [1:0] m);
      logic [10:0] ei;
      logic [10:0] ej;
      ei = a[20:10];
      ej = {a[9:0], 1'b0};
      return {(m[1] ? pix(ei, ej | 11'd1) : 32'h0), (m[0] ? pix(ei, ej) : 32'h0)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_word(input string name, input word_t w,
                             input logic [20:0] a, input logic [1:0] m);
      check({name, "_addr"}, 64'(w.addr), 64'(a));
      check({name, "_mask"}, 64'(w.mask), 64'(m));
      check({name, "_data"}, w.data, exp_data(a, m));
   endtask

   task automatic drive(input logic v, input logic [10:0] pi, input logic [10:0] pj);
      valid        = v;
      i            = pi;
      j            = pj;
      VGA_IN_RED   = pj[7:0];
      VGA_IN_GREEN = pi[7:0];
      VGA_IN_BLUE  = {5'b0, pj[10:8]} ^ 8'hA5;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 11'd0, 11'd0);
   endtask

   word_t split_exp[6];

   initial begin
      vecs[0] = '{11'd5,   11'd0,    800, 400, {11'd5, 10'd0},      2'b11, {11'd5, 10'd399},     2'b11};
      vecs[1] = '{11'd7,   11'd0,    5,   3,   {11'd7, 10'd0},      2'b11, {11'd7, 10'd2},       2'b01};
      vecs[2] = '{11'd9,   11'd1,    4,   3,   {11'd9, 10'd0},      2'b10, {11'd9, 10'd2},       2'b01};
      vecs[3] = '{11'h7FF, 11'd2044, 4,   2,   {11'h7FF, 10'd1022}, 2'b11, {11'h7FF, 10'd1023},  2'b11};
      vecs[4] = '{11'd3,   11'd10,   1,   1,   {11'd3, 10'd5},      2'b01, {11'd3, 10'd5},       2'b01};
      vecs[5] = '{11'd3,   11'd11,   1,   1,   {11'd3, 10'd5},      2'b10, {11'd3, 10'd5},       2'b10};

      split_exp[0] = '{{11'd4,  10'd3}, 2'b01, 64'h0};
      split_exp[1] = '{{11'd4,  10'd3}, 2'b10, 64'h0};
      split_exp[2] = '{{11'd10, 10'd1}, 2'b01, 64'h0};
      split_exp[3] = '{{11'd10, 10'd2}, 2'b10, 64'h0};
      split_exp[4] = '{{11'd11, 10'd2}, 2'b01, 64'h0};
      split_exp[5] = '{{11'd12, 10'd2}, 2'b10, 64'h0};

      Reset_n = 1'b0;
      OutReady = 1'b0;
      valid = 1'b0;
      i = '0;
      j = '0;
      VGA_IN_RED = '0;
      VGA_IN_GREEN = '0;
      VGA_IN_BLUE = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_outvalid",   64'(OutValid),   64'd0);
      check("rst_level",      64'(Level),      64'd0);
      check("rst_overflow",   64'(Overflow),   64'd0);
      check("rst_framestart", 64'(FrameStart), 64'd0);
      check("rst_addr",       64'(OutAddr),    64'd0);
      check("rst_data",       OutData,         64'd0);
      check("rst_mask",       64'(OutMask),    64'd0);
      @(negedge clk);
      Reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Row table, consumer always ready
      OutReady = 1'b1;
      foreach (vecs[v]) begin
         got.delete();
         for (int k = 0; k < vecs[v].n; k++) drive(1'b1, vecs[v].row, 11'(vecs[v].j0 + 11'(k)));
         idle(8);
         check($sformatf("row%0d_words", v), 64'(got.size()), 64'(vecs[v].words));
         if (got.size() > 0) begin
            check_word($sformatf("row%0d_first", v), got[0], vecs[v].a_first, vecs[v].m_first);
            check_word($sformatf("row%0d_last", v), got[got.size()-1], vecs[v].a_last, vecs[v].m_last);
         end
         check($sformatf("row%0d_overflow", v), 64'(Overflow), 64'd0);
      end

      // Latency: pair completed at edge k shows on OutValid after edge k+2
      got.delete();
      drive(1'b1, 11'd12, 11'd0);
      drive(1'b1, 11'd12, 11'd1);
      check("lat_k0_valid", 64'(OutValid), 64'd0);
      idle(1);
      check("lat_k1_valid", 64'(OutValid), 64'd0);
      idle(1);
      check("lat_k2_valid", 64'(OutValid), 64'd1);
      check("lat_k2_addr",  64'(OutAddr),  64'({11'd12, 10'd0}));
      idle(6);

      // Gap-split pair, then double pushes from broken pairs
      got.delete();
      drive(1'b1, 11'd4, 11'd6);
      idle(1);
      drive(1'b1, 11'd4, 11'd7);
      drive(1'b1, 11'd10, 11'd2);
      drive(1'b1, 11'd10, 11'd5);
      drive(1'b1, 11'd11, 11'd4);
      drive(1'b1, 11'd12, 11'd5);
      idle(8);
      check("split_words", 64'(got.size()), 64'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < got.size())
            check_word($sformatf("split%0d", k), got[k], split_exp[k].addr, split_exp[k].mask);
      end

      // Overflow: 20 pairs into a stalled consumer
      got.delete();
      OutReady = 1'b0;
      for (int k = 0; k < 40; k++) drive(1'b1, 11'd6, 11'(k));
      idle(6);
      check("ovf_level",    64'(Level),    64'd8);
      check("ovf_valid",    64'(OutValid), 64'd1);
      check("ovf_flag",     64'(Overflow), 64'd1);
      check("ovf_head",     64'(OutAddr),  64'({11'd6, 10'd0}));
      idle(3);
      check("ovf_stable_addr", 64'(OutAddr), 64'({11'd6, 10'd0}));
      check("ovf_stable_data", OutData, exp_data({11'd6, 10'd0}, 2'b11));
      OutReady = 1'b1;
      idle(12);
      check("ovf_drained",  64'(got.size()), 64'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < got.size()) check_word($sformatf("ovf_w%0d", k), got[k], {11'd6, 10'(k)}, 2'b11);
      end
      check("ovf_level_empty", 64'(Level),    64'd0);
      check("ovf_sticky",      64'(Overflow), 64'd1);
      drive(1'b1, 11'd0, 11'd0);
      check("fs_pulse",        64'(FrameStart), 64'd1);
      idle(1);
      check("fs_clears_ovf",   64'(Overflow),   64'd0);
      check("fs_one_cycle",    64'(FrameStart), 64'd0);
      idle(6);

      // Mid-line reset with five words queued and an even pixel held
      got.delete();
      OutReady = 1'b0;
      for (int k = 0; k < 10; k++) drive(1'b1, 11'd8, 11'(k));
      idle(3);
      check("rstq_level_before", 64'(Level), 64'd5);
      drive(1'b1, 11'd8, 11'd10);
      drive(1'b0, 11'd0, 11'd0);
      #2;
      Reset_n = 1'b0;
      #1;
      check("rstq_valid", 64'(OutValid), 64'd0);
      check("rstq_level", 64'(Level),    64'd0);
      @(negedge clk);
      Reset_n = 1'b1;
      @(posedge clk);
      #1;
      got.delete();
      OutReady = 1'b1;
      drive(1'b1, 11'd1, 11'd2);
      drive(1'b1, 11'd1, 11'd3);
      idle(8);
      check("rstq_words", 64'(got.size()), 64'd1);
      if (got.size() > 0) check_word("rstq_pair", got[0], {11'd1, 10'd1}, 2'b11);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
